nco_quad: RTL
=============

# nco_quad

Synthesizable parametrised quadrature numerically-controlled oscillator. It produces fixed-point sine and cosine samples at a programmable sample rate and frequency. A programmable divider generates the sample tick, and a phase accumulator advances once per tick. Each phase value is folded to a quarter wave and evaluated with a pipelined 7th-order odd polynomial. The block is the stimulus and reference-tone source for the signal-processing datapaths and their benches.

## Interface
Parameters:
- PHASE_W, 32, phase accumulator and tuning-word width (≥ 20)
- POLY_W, 18, fractional bits of quarter-wave argument y and of polynomial arithmetic
- OUT_W, 16, signed output sample width
- AMP, 32000, output scale for |sin| = 1.0; must be ≤ 2^(OUT_W-1)-1

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  high: divider and accumulator run; low: both hold, no ticks
- div  in  32  clk cycles per sample; 0 and 1 both mean one tick per cycle
- ftw  in  PHASE_W  frequency tuning word (phase increment per tick)
- poff  in  PHASE_W  phase offset added after the accumulator
- ld  in  1  one-cycle strobe: capture ftw/poff into shadow registers
- sync_clr  in  1  one-cycle strobe: zero accumulator at next tick
- sin_out  out  OUT_W  signed sine sample
- cos_out  out  OUT_W  signed cosine sample
- out_valid  out  1  one-cycle strobe, samples updated this cycle

## Operation
- Reset (reset=0): divider cnt=0, accumulator=0, shadow and active ftw/poff=0, pipeline cleared, sin_out=0, cos_out=0, out_valid=0. Reset mid-pipeline discards in-flight samples; no valid strobe follows.
- Divider: tick when enable && cnt ≥ div-1, then cnt←0; otherwise cnt←cnt+1. Changing div mid-count takes effect on the next compare. If cnt already exceeds the new div-1, tick immediately.
- ld: the shadow registers capture ftw and poff. The active registers take the shadow values on the next tick, so an update never splits a sample. If ld and a tick coincide, the new values are latched into shadow only and become active on the following tick.
- Tick: launch phase p = acc + poff_active (mod 2^PHASE_W) into the pipeline, then acc ← acc + ftw_active. sync_clr pending: launch p = poff_active, then acc ← ftw_active. sync_clr with enable low stays pending until the next tick.
- Fold: q = p[PHASE_W-1:PHASE_W-2]; r = next POLY_W bits (truncated).
  - Argument: y = r for q=0,2; y = 2^POLY_W - r for q=1,3. y is POLY_W+1 bits so that y=1.0 is exact.
  - Sign: negate for q=2,3.
- Polynomial: s = 1.570794·y − 0.645962·y³ + 0.079692·y⁵ − 0.004681712·y⁷.
  - Coefficients are Q2.POLY_W, round-to-nearest.
  - Each product is truncated back to POLY_W fractional bits.
- Output: round(s·AMP) with sign applied, saturated to ±(2^(OUT_W-1)-1).
- Cosine: the same computation on p + 2^(PHASE_W-2).
- Accuracy: |error| ≤ 8 LSB against ideal AMP·sin(2π·p/2^PHASE_W).

## Timing
- Tick at cycle t: sin_out/cos_out update and out_valid=1 at cycle t+6. Outputs hold between strobes.
- Pipeline stages:
  1. fold
  2. y²
  3. y³
  4. y⁵
  5. y⁷ and coefficient products
  6. sum, scale, sign, saturate
- Fully pipelined: div ≤ 1 yields out_valid every cycle after a 6-cycle fill.
- enable low does not stall the pipeline; in-flight samples drain and emit.

## Configuration
- NCO_QUAD_EN defined: cosine path instantiated, cos_out live.
- NCO_QUAD_EN undefined: cosine path removed, cos_out tied to 0. sin_out timing and values are unchanged.

## Structure
- Package nco_pkg: coefficient constants (Q2.POLY_W, derived from POLY_W), latency constant NCO_LAT=6, quadrant fold function.
- Sub-module nco_sin_poly: phase in, 6-stage fold/polynomial/scale pipeline, signed sample out. It is instantiated once for sine and once for cosine (the latter under NCO_QUAD_EN).
- nco_quad top holds the divider, shadow/active registers, accumulator and valid-delay line.

## Test plan
- Defaults, div=1, ftw=2^26, ld pulse then reset release:
  - Sample n=0: sin=0, cos≈32000.
  - n=16: sin≈32000, cos≈0.
  - n=32: sin≈0.
  - n=48: sin≈-32000.
  - All samples within ±8 LSB; out_valid every cycle after the 6-cycle fill.
- div=10000, ftw=2^26: out_valid exactly every 10000 clk, first strobe 6 cycles after the first tick; 64 samples per period (≈15.6 Hz at 10 MHz).
- Frequency switch: ld with ftw=2^27 mid-run between ticks. The next launched sample still uses 2^26; the step doubles from the tick after; no sample is skipped or duplicated.
- poff=2^30 with ftw=0: sin constant ≈32000, cos ≈0. Then sync_clr: next launch phase = poff, accumulator restarts.
- Reset asserted 3 cycles after a tick: no out_valid for that sample; all outputs 0 until the first post-reset tick + 6.
- Boundary phases p = 2^30 and p = 0x80000000 (y=1.0, sign flip at q=2): sin=+32000±8 and 0±8 respectively; no overflow; saturation never exceeded ±32767.

Source files
------------

// File: rtl/nco_pkg.sv
// nco_pkg: shared constants and helpers for the quadrature NCO.
//   NCO_LAT   - launch-to-output latency in clk cycles
//   K1..K7    - odd polynomial coefficients (magnitudes; signs are applied in the sum)
//   nco_coef  - quantise a coefficient to Q2.fw with round-to-nearest
//   nco_fold_y- quarter-wave fold of the phase argument
package nco_pkg;
  localparam int NCO_LAT = 6;

  localparam real K1 = 1.570794;
  localparam real K3 = 0.645962;
  localparam real K5 = 0.079692;
  localparam real K7 = 0.004681712;

  // Real-to-integer cast rounds to nearest.
  function automatic longint nco_coef(input real k, input int fw);
    return longint'(k * (2.0 ** fw));
  endfunction

  // Odd quadrants (1,3) mirror the argument so the polynomial only ever sees
  // [0, 1.0]; y = 1.0 needs the extra integer bit the caller provides.
  function automatic logic [63:0] nco_fold_y(input logic q_odd, input logic [63:0] r, input int fw);
    return q_odd ? ((64'd1 << fw) - r) : r;
  endfunction
endpackage

// File: rtl/nco_sin_poly.sv
// nco_sin_poly: 6-stage fold / polynomial / scale pipeline.
//   clk_i, rst_ni : clock, async active-low reset
//   phase_i       : top POLY_W+2 phase bits (quadrant + quarter-wave fraction)
//   upd_i         : a valid sample sits in stage 5; load it into the output
//   sample_o      : signed sample, held between updates
module nco_sin_poly
  import nco_pkg::*;
#(
  parameter int POLY_W = 18,
  parameter int OUT_W  = 16,
  parameter int AMP    = 32000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [POLY_W+1:0]       phase_i,
  input  logic                    upd_i,
  output logic signed [OUT_W-1:0] sample_o
);
  localparam int YW = POLY_W + 1;  // Q1.POLY_W, holds 1.0 exactly
  localparam int CW = POLY_W + 2;  // Q2.POLY_W
  localparam logic [CW-1:0] C1 = CW'(nco_coef(K1, POLY_W));
  localparam logic [CW-1:0] C3 = CW'(nco_coef(K3, POLY_W));
  localparam logic [CW-1:0] C5 = CW'(nco_coef(K5, POLY_W));
  localparam logic [CW-1:0] C7 = CW'(nco_coef(K7, POLY_W));
  localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

  // Products truncated back to POLY_W fractional bits.
  function automatic logic [YW-1:0] mulq(input logic [YW-1:0] a, input logic [YW-1:0] b);
    return YW'(((2*YW)'(a) * (2*YW)'(b)) >> POLY_W);
  endfunction
  function automatic logic [CW-1:0] mulc(input logic [CW-1:0] c, input logic [YW-1:0] y);
    return CW'(((CW+YW)'(c) * (CW+YW)'(y)) >> POLY_W);
  endfunction

  logic [YW-1:0] y1_q, y1_d;                 // s1: y
  logic [YW-1:0] y2_q, ya2_q;                // s2: y^2, y
  logic [YW-1:0] y3_q, ya3_q, yb3_q;         // s3: y^3, y, y^2
  logic [YW-1:0] y5_q, ya4_q, yb4_q, yc4_q;  // s4: y^5, y, y^3, y^2
  logic [CW-1:0] t1_q, t3_q, t5_q, t7_q;     // s5: coefficient products
  logic [5:1]    neg_q;                      // sign rides along stages 1..5
  logic signed [OUT_W-1:0] smp_d;
  logic signed [63:0] s_w, sc_w;

  assign y1_d = YW'(nco_fold_y(phase_i[POLY_W], 64'(phase_i[POLY_W-1:0]), POLY_W));

  always_comb begin
    s_w  = $signed(64'(t1_q)) - $signed(64'(t3_q)) + $signed(64'(t5_q)) - $signed(64'(t7_q));
    // Round the magnitude before applying the sign so +/- are symmetric.
    sc_w = (s_w * longint'(AMP) + (64'sd1 <<< (POLY_W - 1))) >>> POLY_W;
    if (neg_q[5]) sc_w = -sc_w;
    if (sc_w > MAXV)       sc_w = MAXV;
    else if (sc_w < -MAXV) sc_w = -MAXV;
    smp_d = OUT_W'(sc_w);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y1_q <= '0; y2_q <= '0; ya2_q <= '0;
      y3_q <= '0; ya3_q <= '0; yb3_q <= '0;
      y5_q <= '0; ya4_q <= '0; yb4_q <= '0; yc4_q <= '0;
      t1_q <= '0; t3_q <= '0; t5_q <= '0; t7_q <= '0;
      neg_q <= '0;
      sample_o <= '0;
    end else begin
      y1_q  <= y1_d;
      neg_q <= {neg_q[4:1], phase_i[POLY_W+1]};  // quadrants 2,3 are negative
      y2_q  <= mulq(y1_q, y1_q);
      ya2_q <= y1_q;
      y3_q  <= mulq(y2_q, ya2_q);
      ya3_q <= ya2_q;
      yb3_q <= y2_q;
      y5_q  <= mulq(y3_q, yb3_q);
      ya4_q <= ya3_q;
      yb4_q <= y3_q;
      yc4_q <= yb3_q;
      t1_q  <= mulc(C1, ya4_q);
      t3_q  <= mulc(C3, yb4_q);
      t5_q  <= mulc(C5, y5_q);
      t7_q  <= mulc(C7, mulq(y5_q, yc4_q));  // y^7 formed in the same stage
      if (upd_i) sample_o <= smp_d;
    end
  end
endmodule

// File: rtl/nco_quad.sv
// nco_quad: quadrature NCO top. Divider, shadow/active tuning registers,
// phase accumulator, valid delay line, sine (and optionally cosine) pipeline.
//   clk, reset(async, active-low), enable, div, ftw, poff, ld, sync_clr
//   sin_out, cos_out, out_valid (one-cycle strobe, NCO_LAT cycles after a tick)
// Build option: define NCO_QUAD_EN to instantiate the cosine path; otherwise
// cos_out is tied to 0 and sine behaviour is unchanged.
module nco_quad
  import nco_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int POLY_W  = 18,
  parameter int OUT_W   = 16,
  parameter int AMP     = 32000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             div,
  input  logic [PHASE_W-1:0]      ftw,
  input  logic [PHASE_W-1:0]      poff,
  input  logic                    ld,
  input  logic                    sync_clr,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic                    out_valid
);
  localparam int SH = PHASE_W - POLY_W - 2;

  logic [31:0]        cnt_q, cnt_d, div_m1;
  logic [PHASE_W-1:0] acc_q, acc_d, p_w;
  logic [PHASE_W-1:0] sh_ftw_q, sh_poff_q, act_ftw_q, act_poff_q, ftw_eff, poff_eff;
  logic               ld_pend_q, ld_pend_d, clr_pend_q, clr_pend_d, clr_now, tick;
  logic [NCO_LAT:1]   vld_pipe;
  logic [POLY_W+1:0]  ph_s;

  // div of 0 and 1 both mean a tick every cycle.
  assign div_m1 = (div == 32'd0) ? 32'd0 : div - 32'd1;
  // >= rather than == so a shrunk div ticks at once instead of wrapping.
  assign tick   = enable && (cnt_q >= div_m1);

  // A pending ld commits its shadow values at the tick itself, so the sample
  // launched there already uses them; an ld in the tick cycle waits one tick.
  assign ftw_eff  = ld_pend_q ? sh_ftw_q  : act_ftw_q;
  assign poff_eff = ld_pend_q ? sh_poff_q : act_poff_q;
  assign clr_now  = clr_pend_q | sync_clr;
  assign p_w      = clr_now ? poff_eff : acc_q + poff_eff;

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ld_pend_d  = ld ? 1'b1 : (tick ? 1'b0 : ld_pend_q);
    clr_pend_d = tick ? 1'b0 : clr_now;
    if (enable) cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    if (tick)   acc_d = clr_now ? ftw_eff : acc_q + ftw_eff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      sh_ftw_q   <= '0;
      sh_poff_q  <= '0;
      act_ftw_q  <= '0;
      act_poff_q <= '0;
      ld_pend_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ld_pend_q  <= ld_pend_d;
      clr_pend_q <= clr_pend_d;
      vld_pipe   <= {vld_pipe[NCO_LAT-1:1], tick};
      if (ld) begin
        sh_ftw_q  <= ftw;
        sh_poff_q <= poff;
      end
      if (tick) begin
        act_ftw_q  <= ftw_eff;
        act_poff_q <= poff_eff;
      end
    end
  end

  assign out_valid = vld_pipe[NCO_LAT];
  assign ph_s      = (POLY_W+2)'(p_w >> SH);

  nco_sin_poly #(.POLY_W(POLY_W), .OUT_W(OUT_W), .AMP(AMP)) u_sin (
    .clk_i(clk), .rst_ni(reset), .phase_i(ph_s),
    .upd_i(vld_pipe[NCO_LAT-1]), .sample_o(sin_out)
  );

`ifdef NCO_QUAD_EN
  logic [POLY_W+1:0] ph_c;
  // cos(x) = sin(x + quarter turn)
  assign ph_c = (POLY_W+2)'((p_w + (PHASE_W'(1) << (PHASE_W - 2))) >> SH);

  nco_sin_poly #(.POLY_W(POLY_W), .OUT_W(OUT_W), .AMP(AMP)) u_cos (
    .clk_i(clk), .rst_ni(reset), .phase_i(ph_c),
    .upd_i(vld_pipe[NCO_LAT-1]), .sample_o(cos_out)
  );
`else
  assign cos_out = '0;
`endif
endmodule
